// File: rtl/lzma2_crc_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : lzma2_crc_scheduler
// Shares one lzma2_crc engine among NUM_REQ frame requesters, round-robin per
// frame, and returns a tagged CRC or error result over a valid/ready handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module lzma2_crc_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*256-1:0]     req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*5-1:0]       req_last_bytes,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       eng_clear,
  output logic [255:0]               eng_data,
  output logic                       eng_valid,
  output logic                       eng_last,
  output logic [4:0]                 eng_last_bytes,
  input  logic                       eng_ready,
  input  logic [31:0]                eng_crc,
  input  logic                       eng_crc_valid,
  input  logic                       eng_error,
  input  logic [3:0]                 eng_error_code,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [31:0]                res_crc,
  output logic                       res_error,
  output logic [3:0]                 res_error_code,
  output logic                       busy
);

  localparam int                c_id_w       = $clog2(NUM_REQ);
  localparam int                c_to_w       = $clog2(TIMEOUT + 1);
  localparam logic [c_id_w:0]   c_num_req    = (c_id_w + 1)'(NUM_REQ);
  localparam logic [c_id_w-1:0] c_last_id    = c_id_w'(NUM_REQ - 1);
  localparam logic [c_id_w-1:0] c_id_one     = c_id_w'(1);
  localparam logic [c_to_w-1:0] c_to_last    = c_to_w'(TIMEOUT - 1);
  localparam logic [c_to_w-1:0] c_to_one     = c_to_w'(1);
  localparam logic [10:0]       c_beat_limit = 11'd1025;
  localparam logic [10:0]       c_beat_max   = 11'h7FF;
  localparam logic [10:0]       c_beat_one   = 11'd1;
  localparam logic [3:0]        c_err_ovf    = 4'h1;
  localparam logic [3:0]        c_err_tmo    = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_RESULT   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_id_w-1:0]   r_gnt_id;
  logic [10:0]         r_beat_cnt;
  logic                r_err_lat;
  logic [3:0]          r_err_code;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_eng_clear;
  logic                r_busy;
  logic                r_res_valid;
  logic [c_id_w-1:0]   r_res_id;
  logic [31:0]         r_res_crc;
  logic                r_res_error;
  logic [3:0]          r_res_error_code;

  logic [255:0]        w_data_arr [NUM_REQ];
  logic [4:0]          w_lb_arr   [NUM_REQ];
  logic                w_streaming;
  logic                w_gnt_valid;
  logic                w_accept;
  logic [10:0]         w_beat_next;
  logic [c_id_w-1:0]   w_rr_next;
  logic [c_id_w-1:0]   w_pick;
  logic                w_found;
  logic [c_id_w:0]     w_cand;

  assign w_streaming = (r_state == S_STREAM);
  assign w_gnt_valid = req_valid[r_gnt_id];
  // After an error the frame is drained: ready regardless of the engine.
  assign w_accept    = w_streaming && w_gnt_valid && (r_err_lat || eng_ready);
  assign w_beat_next = (r_beat_cnt == c_beat_max) ? r_beat_cnt : r_beat_cnt + c_beat_one;
  assign w_rr_next   = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + c_id_one;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_data_arr[gi] = req_data[gi*256 +: 256];
      assign w_lb_arr[gi]   = req_last_bytes[gi*5 +: 5];
      assign req_ready[gi]  = w_streaming && (r_gnt_id == c_id_w'(gi)) &&
                              (r_err_lat || eng_ready);
    end
  endgenerate

  // First requesting index at or after r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (c_id_w + 1)'(k);
      if (w_cand >= c_num_req) begin
        w_cand = w_cand - c_num_req;
      end
      if (!w_found && req_valid[w_cand[c_id_w-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[c_id_w-1:0];
      end
    end
  end

  assign eng_clear      = r_eng_clear;
  assign eng_data       = w_data_arr[r_gnt_id];
  assign eng_last       = req_last[r_gnt_id];
  assign eng_last_bytes = w_lb_arr[r_gnt_id];
  assign eng_valid      = w_streaming && w_gnt_valid && !r_err_lat;

  assign res_valid      = r_res_valid;
  assign res_id         = r_res_id;
  assign res_crc        = r_res_crc;
  assign res_error      = r_res_error;
  assign res_error_code = r_res_error_code;
  assign busy           = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_rr_ptr         <= '0;
      r_gnt_id         <= '0;
      r_beat_cnt       <= '0;
      r_err_lat        <= 1'b0;
      r_err_code       <= '0;
      r_to_cnt         <= '0;
      r_eng_clear      <= 1'b0;
      r_busy           <= 1'b0;
      r_res_valid      <= 1'b0;
      r_res_id         <= '0;
      r_res_crc        <= '0;
      r_res_error      <= 1'b0;
      r_res_error_code <= '0;
    end else begin
      r_eng_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_id    <= w_pick;
            r_beat_cnt  <= '0;
            r_err_lat   <= 1'b0;
            r_err_code  <= '0;
            r_eng_clear <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          r_state <= S_STREAM;
        end

        S_STREAM: begin
          if (!r_err_lat && eng_error) begin
            r_err_lat  <= 1'b1;
            r_err_code <= eng_error_code;
          end else if (!r_err_lat && w_accept && (w_beat_next == c_beat_limit)) begin
            r_err_lat  <= 1'b1;
            r_err_code <= c_err_ovf;
          end
          if (w_accept) begin
            r_beat_cnt <= w_beat_next;
            if (eng_last) begin
              r_to_cnt <= '0;
              r_state  <= S_WAIT_RES;
            end
          end
        end

        S_WAIT_RES: begin
          r_to_cnt <= r_to_cnt + c_to_one;
          // Error outranks a simultaneous CRC; an earlier latched error keeps its code.
          if (r_err_lat || eng_error) begin
            r_res_valid      <= 1'b1;
            r_res_id         <= r_gnt_id;
            r_res_crc        <= '0;
            r_res_error      <= 1'b1;
            r_res_error_code <= r_err_lat ? r_err_code : eng_error_code;
            r_state          <= S_RESULT;
          end else if (eng_crc_valid) begin
            r_res_valid      <= 1'b1;
            r_res_id         <= r_gnt_id;
            r_res_crc        <= eng_crc;
            r_res_error      <= 1'b0;
            r_res_error_code <= '0;
            r_state          <= S_RESULT;
          end else if (r_to_cnt == c_to_last) begin
            r_res_valid      <= 1'b1;
            r_res_id         <= r_gnt_id;
            r_res_crc        <= '0;
            r_res_error      <= 1'b1;
            r_res_error_code <= c_err_tmo;
            r_state          <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= w_rr_next;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lzma2_crc_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_lzma2_crc_scheduler
// Scoreboard bench for lzma2_crc_scheduler with a behavioural engine model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lzma2_crc_scheduler;

  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [N*256-1:0] req_data;
  logic [N*5-1:0]   req_last_bytes;
  logic             eng_clear, eng_valid, eng_last, eng_ready;
  logic [255:0]     eng_data;
  logic [4:0]       eng_last_bytes;
  logic [31:0]      eng_crc;
  logic             eng_crc_valid, eng_error;
  logic [3:0]       eng_error_code;
  logic             res_valid, res_ready, res_error, busy;
  logic [1:0]       res_id;
  logic [31:0]      res_crc;
  logic [3:0]       res_error_code;

  lzma2_crc_scheduler #(.NUM_REQ(N), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_last_bytes(req_last_bytes), .req_ready(req_ready),
    .eng_clear(eng_clear), .eng_data(eng_data), .eng_valid(eng_valid),
    .eng_last(eng_last), .eng_last_bytes(eng_last_bytes), .eng_ready(eng_ready),
    .eng_crc(eng_crc), .eng_crc_valid(eng_crc_valid), .eng_error(eng_error),
    .eng_error_code(eng_error_code),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_crc(res_crc), .res_error(res_error), .res_error_code(res_error_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [255:0] d; logic last; logic [4:0] lb;} beat_t;
  typedef struct packed {logic [1:0] id; logic [31:0] crc; logic err; logic [3:0] code;} res_t;

  beat_t rq [N][$];
  res_t  sb [$];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [255:0] d,
                                      input logic [4:0] lb);
    logic [31:0] x;
    x = a;
    for (int w = 0; w < 8; w++) x = {x[26:0], x[31:27]} ^ d[w*32 +: 32] ^ 32'(w);
    return x ^ {27'd0, lb};
  endfunction

  // Engine model: clear resets the accumulator, result one cycle after the last beat.
  bit          tog_mode = 1'b0;
  bit          no_crc   = 1'b0;
  int          err_beat = 0;
  int          ebeats   = 0;
  logic [31:0] acc      = SEED;

  assign eng_error      = (err_beat != 0) && eng_valid && eng_ready && (ebeats == err_beat - 1);
  assign eng_error_code = 4'h1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_ready     <= 1'b1;
      eng_crc_valid <= 1'b0;
      eng_crc       <= '0;
    end else begin
      eng_crc_valid <= 1'b0;
      eng_ready     <= tog_mode ? ~eng_ready : 1'b1;
      if (eng_clear) begin
        acc    <= SEED;
        ebeats <= 0;
      end else if (eng_valid && eng_ready) begin
        acc    <= mix(acc, eng_data, eng_last ? eng_last_bytes : 5'd0);
        ebeats <= ebeats + 1;
        if (eng_last && !no_crc) begin
          eng_crc_valid <= 1'b1;
          eng_crc       <= mix(acc, eng_data, eng_last_bytes);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester driver: pops beats accepted in the previous cycle.
  initial begin : drv
    logic [N-1:0] acc_m;
    req_valid = '0; req_data = '0; req_last = '0; req_last_bytes = '0;
    forever begin
      @(negedge clk);
      acc_m = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_m[i] && rq[i].size() > 0) rq[i].delete(0);
        if (rq[i].size() > 0) begin
          req_valid[i]              = 1'b1;
          req_data[i*256 +: 256]    = rq[i][0].d;
          req_last[i]               = rq[i][0].last;
          req_last_bytes[i*5 +: 5]  = rq[i][0].lb;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  int   t_seen = 0, clear_cyc = 0, res_rise_cyc = 0, last_acc_cyc = 0, clear_cnt = 0;
  int   acc_beats [N] = '{default: 0};
  int   drained = 0, forwarded = 0, rdy_viol = 0, unstable = 0;
  logic prev_hold = 1'b0, prev_rv = 1'b0;
  res_t prev_snap = '0;

  initial begin : mon
    res_t cur, exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        prev_rv   = 1'b0;
      end else begin
        if (!busy && req_valid != '0) t_seen = cyc;
        if (eng_clear) begin clear_cnt++; clear_cyc = cyc; end
        if ($countones(req_ready) > 1 || (req_ready != '0 && !busy)) rdy_viol++;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            acc_beats[i]++;
            if (eng_valid) forwarded++; else drained++;
            if (req_last[i]) last_acc_cyc = cyc;
          end
        end
        if (res_valid && !prev_rv) res_rise_cyc = cyc;
        cur = {res_id, res_crc, res_error, res_error_code};
        if (prev_hold && (!res_valid || cur != prev_snap)) unstable++;
        if (res_valid && res_ready) begin
          if (sb.size() == 0) check_eq("sb_extra_result", 64'(res_id), 64'hFF);
          else begin
            exp = sb.pop_front();
            check_eq("res_id", 64'(res_id), 64'(exp.id));
            check_eq("res_crc", 64'(res_crc), 64'(exp.crc));
            check_eq("res_error", 64'(res_error), 64'(exp.err));
            check_eq("res_error_code", 64'(res_error_code), 64'(exp.code));
          end
        end
        prev_hold = res_valid && !res_ready;
        prev_snap = cur;
        prev_rv   = res_valid;
      end
    end
  end

  task automatic send_frame(input int r, input int nb, input bit zero, input bit err,
                            input logic [3:0] code);
    beat_t       b;
    res_t        e;
    logic [31:0] c;
    c = SEED;
    for (int k = 0; k < nb; k++) begin
      b.d    = zero ? '0 : {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
      b.last = (k == nb - 1);
      b.lb   = (b.last && !zero) ? 5'($urandom_range(1, 31)) : 5'd0;
      c      = mix(c, b.d, b.lb);
      rq[r].push_back(b);
    end
    e.id   = 2'(r);
    e.crc  = err ? 32'd0 : c;
    e.err  = err;
    e.code = err ? code : 4'd0;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || (rq[0].size() + rq[1].size() + rq[2].size() +
            rq[3].size()) != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_pending_results"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_eng"}, 64'({eng_clear, eng_valid}), 64'd0);
    check_eq({tag, "_res"}, 64'({res_valid, res_id, res_crc, res_error, res_error_code}), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: sim time %0t reached, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin : main
    int n;
    res_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_reset_outs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single requester, one zero beat
    @(negedge clk); #2;
    send_frame(0, 1, 1'b1, 1'b0, 4'd0);
    wait_done("single", 100);
    check_eq("single_clear_lat", 64'(clear_cyc - t_seen), 64'd1);
    check_eq("single_res_lat", 64'(res_rise_cyc - t_seen), 64'd4);

    // Round-robin with all requesters active
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    clear_cnt = 0; rdy_viol = 0;
    #2;
    send_frame(0, 2, 1'b0, 1'b0, 4'd0);
    send_frame(1, 2, 1'b0, 1'b0, 4'd0);
    send_frame(2, 2, 1'b0, 1'b0, 4'd0);
    send_frame(3, 2, 1'b0, 1'b0, 4'd0);
    send_frame(0, 2, 1'b0, 1'b0, 4'd0);
    wait_done("rr", 400);
    check_eq("rr_clear_count", 64'(clear_cnt), 64'd5);
    check_eq("rr_ready_violations", 64'(rdy_viol), 64'd0);

    // Backpressure on engine and result
    tog_mode = 1'b1; res_ready = 1'b0; acc_beats[2] = 0; unstable = 0;
    @(negedge clk); #2;
    send_frame(2, 4, 1'b0, 1'b0, 4'd0);
    n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    check_eq("bp_res_valid", 64'(res_valid), 64'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_still_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check_eq("bp_idle_after_ready", 64'(busy), 64'd0);
    check_eq("bp_beats", 64'(acc_beats[2]), 64'd4);
    check_eq("bp_res_stable", 64'(unstable), 64'd0);
    tog_mode = 1'b0;
    wait_done("bp", 100);

    // Engine error on beat 2 of 4
    err_beat = 2; drained = 0; forwarded = 0;
    @(negedge clk); #2;
    send_frame(3, 4, 1'b0, 1'b1, 4'h1);
    wait_done("err", 200);
    check_eq("err_drained_beats", 64'(drained), 64'd2);
    check_eq("err_forwarded_beats", 64'(forwarded), 64'd2);
    err_beat = 0;

    // Engine never returns a CRC
    no_crc = 1'b1;
    @(negedge clk); #2;
    send_frame(1, 1, 1'b0, 1'b1, 4'h8);
    wait_done("tmo", 300);
    check_eq("tmo_latency", 64'(res_rise_cyc - last_acc_cyc), 64'd65);
    no_crc = 1'b0;

    // Reset during beat 3, then resend
    acc_beats[1] = 0;
    @(negedge clk); #2;
    send_frame(1, 4, 1'b0, 1'b0, 4'd0);
    n = 0;
    while (acc_beats[1] < 2 && n < 100) begin @(negedge clk); n++; end
    check_eq("mid_beats_before_rst", 64'(acc_beats[1]), 64'd2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outs("mid_reset");
    @(posedge clk); #2;
    rq[1].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_cnt = 0;
    send_frame(1, 4, 1'b0, 1'b0, 4'd0);
    wait_done("resend", 200);
    check_eq("resend_clear_count", 64'(clear_cnt), 64'd1);
    check_eq("final_ready_violations", 64'(rdy_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lzma2_crc_scheduler.md
# lzma2_crc_scheduler

Shares a single `lzma2_crc` engine among `NUM_REQ` frame-based requesters, such as the compressor input tap and the decompressor output verifier. It arbitrates round-robin at frame granularity and clears the engine before every frame. It streams the granted requester's 32-byte beats into the engine, then returns a tagged CRC or error result through a valid/ready handshake. It sits between the LZMA2 stream datapaths and the CRC engine.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles to wait for an engine result after the last beat.

Ports (`N` = `NUM_REQ`):
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input N: requester i has a beat.
- `req_data` input N*256: beat of requester i at `[i*256 +: 256]`.
- `req_last` input N: beat is the last of its frame.
- `req_last_bytes` input N*5: valid bytes in the last beat, at `[i*5 +: 5]`; passed to the engine unchanged.
- `req_ready` output N: beat of requester i accepted this cycle when `req_valid[i]` is also 1.
- `eng_clear` output 1: engine clear pulse.
- `eng_data` output 256, `eng_valid` output 1, `eng_last` output 1, `eng_last_bytes` output 5: beat path to the engine.
- `eng_ready` input 1, `eng_crc` input 32, `eng_crc_valid` input 1, `eng_error` input 1, `eng_error_code` input 4: engine returns.
- `res_valid` output 1, `res_ready` input 1: result handshake.
- `res_id` output `$clog2(N)`: requester index of the result.
- `res_crc` output 32: final CRC; 0 when `res_error`=1.
- `res_error` output 1, `res_error_code` output 4: frame failed, with its cause.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, CLEAR, STREAM, WAIT_RES, RESULT.
- **IDLE**: if any `req_valid` is 1, grant the first requester at or after `rr_ptr`, searching upward with wrap. Register the grant in `gnt_id` and go to CLEAR. With no request, stay in IDLE.
- **CLEAR**: `eng_clear`=1 for exactly one cycle, then go to STREAM. No beat is forwarded in CLEAR.
- **STREAM**:
  - `eng_data`, `eng_last` and `eng_last_bytes` are muxed combinationally from `gnt_id`.
  - `eng_valid` = `req_valid[gnt_id]`; `req_ready[gnt_id]` = `eng_ready`. All other `req_ready` bits are 0.
  - A beat is accepted when `req_valid[gnt_id]` and `eng_ready` are both 1; each accepted beat increments the 11-bit `beat_cnt`.
  - An accepted beat with `req_last` moves the FSM to WAIT_RES.
- **Engine error while streaming**: if `eng_error` rises in STREAM, latch `err_lat`=1 and `eng_error_code`. The remaining beats of the frame are still accepted (so the requester drains) but are not forwarded: `eng_valid`=0 and `req_ready[gnt_id]`=1.
- **beat_cnt overflow**: reaching 1025 sets `err_lat` with code 4'h1, treated the same as an engine error.
- **WAIT_RES** (the timeout counter is cleared on entry):
  - `eng_crc_valid` captures `eng_crc` and goes to RESULT.
  - `eng_error`, or `err_lat` already set, gives an error result with the engine code and goes to RESULT.
  - Counter reaching `TIMEOUT` gives an error result with code 4'h8 and goes to RESULT.
  - `eng_crc_valid` and `eng_error` in the same cycle: error wins.
- **RESULT**: `res_valid`=1 with `res_id`=`gnt_id`. Outputs are held stable until `res_ready`=1, then set `rr_ptr` = `gnt_id`+1 (mod N) and go to IDLE.
- Error codes: 0 none, 1 overflow, 2 invalid size, 8 timeout.
- A requester that deasserts `req_valid` mid-frame simply stalls STREAM. There is no timeout in STREAM.

## Timing
- Reset values: FSM=IDLE; `rr_ptr`=0; all `req_ready`=0; `eng_clear`=0; `eng_valid`=0; `res_valid`=0; `res_id`=0; `res_crc`=0; `res_error`=0; `res_error_code`=0; `busy`=0.
- Reset asserted mid-frame aborts immediately: no result is produced and the partial frame is lost. After release, the first frame gets a fresh `eng_clear`.
- Single-beat frame, with `req_valid` first seen in IDLE at cycle t:
  - t+1: CLEAR.
  - t+2: beat accepted.
  - t+3: WAIT_RES sees `eng_crc_valid` (the engine registers its result one cycle after the last beat).
  - t+4: `res_valid`=1.
- Multi-beat frame: one beat per cycle while `eng_ready` and `req_valid` are both 1.
- Frame-to-frame overhead: 2 cycles plus result acceptance. A new grant is evaluated in the IDLE cycle after `res_ready`.
- Grants are never preempted mid-frame. Fairness: every requester is granted within N frames.

## Test plan
- **Single requester**: req0 sends one beat of 32 zero bytes (`last_bytes`=0) with `res_ready`=1 -> `eng_clear` pulses at t+1, `res_valid` at t+4 with `res_id`=0 and `res_crc` equal to the engine output, `res_error`=0.
- **Round-robin**: all 4 requesters hold `req_valid`=1, each sending 2-beat frames -> grants in order 0,1,2,3,0; exactly one `eng_clear` per frame; no `req_ready` to non-granted requesters.
- **Backpressure**: `eng_ready` toggles every cycle during a 4-beat frame, and `res_ready` is held 0 for 5 cycles -> `beat_cnt`=4; `res_*` stable throughout the hold; IDLE is reached one cycle after `res_ready`=1.
- **Engine error**: engine model asserts `eng_error` with code 4'h1 on beat 2 of 4 -> beats 3 and 4 are accepted but `eng_valid`=0; result has `res_error`=1, `res_error_code`=4'h1, `res_crc`=0.
- **Timeout**: engine never asserts `eng_crc_valid` after the last beat -> `res_valid` arrives 64 cycles after WAIT_RES entry with `res_error_code`=4'h8.
- **Reset mid-stream**: `rst` is pulsed during beat 3 of a frame -> all outputs return to their reset values in the same cycle; the re-sent frame completes with the correct CRC.
